// File: rtl/lsu_pkg.sv
// Shared encodings, FSM states and lane helpers for the load/store unit
// and its lane aligner.
package lsu_pkg;

  localparam logic [1:0] SIZE_B = 2'b00;
  localparam logic [1:0] SIZE_H = 2'b01;
  localparam logic [1:0] SIZE_W = 2'b10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2,
    RESP = 2'd3
  } lsu_state_e;

  localparam logic [31:0] LANE_MASK_B = 32'h0000_00ff;
  localparam logic [31:0] LANE_MASK_H = 32'h0000_ffff;
  localparam logic [31:0] LANE_MASK_W = 32'hffff_ffff;

  // Bit position of the addressed lane inside the little-endian word.
  function automatic logic [4:0] lane_shift(input logic [1:0] offset);
    return {offset, 3'b000};
  endfunction

  function automatic logic [31:0] lane_mask(input logic [1:0] size);
    logic [31:0] m;
    case (size)
      SIZE_B:  m = LANE_MASK_B;
      SIZE_H:  m = LANE_MASK_H;
      default: m = LANE_MASK_W;
    endcase
    return m;
  endfunction

  // Size 11 has no legal alignment at all.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] offset);
    logic bad;
    case (size)
      SIZE_B:  bad = 1'b0;
      SIZE_H:  bad = offset[0];
      SIZE_W:  bad = (offset != 2'b00);
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational lane steering: extracts and extends load lanes, and merges
// sub-word store data into an existing word.
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [31:0] load_word_i,
  input  logic [1:0]  offset_i,
  input  logic [1:0]  size_i,
  input  logic        unsigned_i,
  output logic [31:0] load_data_o,
  input  logic [31:0] old_word_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] merged_o
);

  logic [4:0]  shamt;
  logic [31:0] shifted;
  logic [31:0] mask;

  assign shamt   = lane_shift(offset_i);
  assign shifted = load_word_i >> shamt;
  assign mask    = lane_mask(size_i) << shamt;

  // Word loads are always aligned, so the unshifted word passes straight through.
  always_comb begin
    load_data_o = shifted;
    case (size_i)
      SIZE_B: load_data_o = unsigned_i ? (shifted & LANE_MASK_B)
                                       : {{24{shifted[7]}}, shifted[7:0]};
      SIZE_H: load_data_o = unsigned_i ? (shifted & LANE_MASK_H)
                                       : {{16{shifted[15]}}, shifted[15:0]};
      default: load_data_o = shifted;
    endcase
  end

  assign merged_o = (old_word_i & ~mask) | ((wdata_i << shamt) & mask);

endmodule

// File: rtl/load_store_unit.sv
// MEM-stage load/store initiator: one request at a time, sub-word stores
// are read-modify-write on the addressed 32-bit word.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W+1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err,
  output logic [ADDR_W-1:0] mem_read_addr,
  output logic [ADDR_W-1:0] mem_write_addr,
  output logic [DATA_W-1:0] mem_write_data,
  output logic              mem_read,
  output logic              mem_write,
  input  logic [DATA_W-1:0] mem_read_data
);

  lsu_state_e        state_q, state_d;
  logic              write_q, write_d;
  logic [1:0]        size_q, size_d;
  logic              unsigned_q, unsigned_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic [1:0]        offset_q, offset_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              err_q, err_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [DATA_W-1:0] mwdata_q, mwdata_d;

  logic              req_misaligned;
  logic [DATA_W-1:0] load_data;
  logic [DATA_W-1:0] merged_word;

  assign req_misaligned = is_misaligned(req_size, req_addr[1:0]);

  lsu_lane_align u_lane_align (
    .load_word_i (mem_read_data),
    .offset_i    (offset_q),
    .size_i      (size_q),
    .unsigned_i  (unsigned_q),
    .load_data_o (load_data),
    .old_word_i  (mem_read_data),
    .wdata_i     (wdata_q),
    .merged_o    (merged_word)
  );

  // Every memory-facing output comes straight from a register, so strobes
  // drop the instant reset is asserted.
  assign req_ready      = (state_q == IDLE);
  assign resp_valid     = (state_q == RESP);
  assign resp_err       = (state_q == RESP) && err_q;
  assign resp_rdata     = rdata_q;
  assign mem_read       = (state_q == RD);
  assign mem_write      = (state_q == WR);
  assign mem_read_addr  = waddr_q;
  assign mem_write_addr = waddr_q;
  assign mem_write_data = mwdata_q;

  always_comb begin
    state_d    = state_q;
    write_d    = write_q;
    size_d     = size_q;
    unsigned_d = unsigned_q;
    waddr_d    = waddr_q;
    offset_d   = offset_q;
    wdata_d    = wdata_q;
    err_d      = err_q;
    rdata_d    = rdata_q;
    mwdata_d   = mwdata_q;

    case (state_q)
      IDLE: begin
        if (req_valid) begin
          write_d    = req_write;
          size_d     = req_size;
          unsigned_d = req_unsigned;
          waddr_d    = req_addr[ADDR_W+1:2];
          offset_d   = req_addr[1:0];
          wdata_d    = req_wdata;
          err_d      = req_misaligned;
          if (req_misaligned) begin
            state_d = RESP;
          end else if (req_write && (req_size == SIZE_W)) begin
            mwdata_d = req_wdata;
            state_d  = WR;
          end else begin
            state_d = RD;
          end
        end
      end
      // The read word is consumed on the edge leaving RD, either as a load
      // result or as the base for a sub-word merge.
      RD: begin
        if (write_q) begin
          mwdata_d = merged_word;
          state_d  = WR;
        end else begin
          rdata_d = load_data;
          state_d = RESP;
        end
      end
      WR: begin
        rdata_d = '0;
        state_d = RESP;
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      write_q    <= 1'b0;
      size_q     <= SIZE_B;
      unsigned_q <= 1'b0;
      waddr_q    <= '0;
      offset_q   <= 2'b00;
      wdata_q    <= '0;
      err_q      <= 1'b0;
      rdata_q    <= '0;
      mwdata_q   <= '0;
    end else begin
      state_q    <= state_d;
      write_q    <= write_d;
      size_q     <= size_d;
      unsigned_q <= unsigned_d;
      waddr_q    <= waddr_d;
      offset_q   <= offset_d;
      wdata_q    <= wdata_d;
      err_q      <= err_d;
      rdata_q    <= rdata_d;
      mwdata_q   <= mwdata_d;
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed table, queued handshake,
// randomized traffic against a behavioural model, and reset during a write.
module tb_load_store_unit;
  import lsu_pkg::*;

  localparam int ADDR_W = 8;

  typedef struct {
    logic        write;
    logic [1:0]  size;
    logic        uns;
    logic [9:0]  addr;
    logic [31:0] wdata;
    logic [31:0] expRdata;
    logic        expErr;
    int          expLat;
    int          expRd;
    int          expWr;
    logic [31:0] expWrData;
  } vec_t;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [1:0]        req_size;
  logic              req_unsigned;
  logic [ADDR_W+1:0] req_addr;
  logic [31:0]       req_wdata;
  logic              resp_valid;
  logic [31:0]       resp_rdata;
  logic              resp_err;
  logic [ADDR_W-1:0] mem_read_addr;
  logic [ADDR_W-1:0] mem_write_addr;
  logic [31:0]       mem_write_data;
  logic              mem_read;
  logic              mem_write;
  logic [31:0]       mem_read_data;

  int total = 0;
  int bad   = 0;

  logic [31:0] tbMem [256];
  logic        clearMem;
  int          rdCount = 0;
  int          wrCount = 0;
  logic [7:0]  lastWrAddr = '0;
  logic [31:0] lastWrData = '0;

  logic [31:0] modelMem [256];
  logic [31:0] modelRdata;

  always #5 clk = ~clk;

  load_store_unit #(.ADDR_W(ADDR_W), .DATA_W(32)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_write      (req_write),
    .req_size       (req_size),
    .req_unsigned   (req_unsigned),
    .req_addr       (req_addr),
    .req_wdata      (req_wdata),
    .resp_valid     (resp_valid),
    .resp_rdata     (resp_rdata),
    .resp_err       (resp_err),
    .mem_read_addr  (mem_read_addr),
    .mem_write_addr (mem_write_addr),
    .mem_write_data (mem_write_data),
    .mem_read       (mem_read),
    .mem_write      (mem_write),
    .mem_read_data  (mem_read_data)
  );

  assign mem_read_data = tbMem[mem_read_addr];

  always @(posedge clk) begin
    if (clearMem) begin
      for (int i = 0; i < 256; i++) tbMem[i] <= '0;
    end else if (mem_write) begin
      tbMem[mem_write_addr] <= mem_write_data;
    end
  end

  always @(negedge clk) begin
    if (mem_read) rdCount++;
    if (mem_write) begin
      wrCount++;
      lastWrAddr = mem_write_addr;
      lastWrData = mem_write_data;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("[TB] FAIL %s: got=%h want=%h", name, got, want);
    end
  endtask

  function automatic vec_t mkVec(input logic wr, input logic [1:0] sz, input logic un,
                                 input logic [9:0] ad, input logic [31:0] wd,
                                 input logic [31:0] er, input logic ee, input int el,
                                 input int erd, input int ewr, input logic [31:0] ewd);
    vec_t v;
    v.write = wr; v.size = sz; v.uns = un; v.addr = ad; v.wdata = wd;
    v.expRdata = er; v.expErr = ee; v.expLat = el; v.expRd = erd; v.expWr = ewr;
    v.expWrData = ewd;
    return v;
  endfunction

  // Reference behaviour from the access rules: byte counts, offsets and
  // arithmetic on whole words, with memory kept as a plain array.
  task automatic modelReq(inout vec_t v);
    int unsigned off, wa, nBytes;
    logic [31:0] word, lane, laneRange, newLane, newWord;
    off = v.addr % 4;
    wa  = v.addr / 4;
    nBytes = (v.size == 2'd0) ? 1 : (v.size == 2'd1) ? 2 : (v.size == 2'd2) ? 4 : 0;
    v.expWrData = '0;
    if (nBytes == 0 || (off % nBytes) != 0) begin
      v.expErr = 1'b1; v.expLat = 1; v.expRd = 0; v.expWr = 0;
      v.expRdata = modelRdata;
    end else begin
      v.expErr = 1'b0;
      word = modelMem[wa];
      laneRange = (nBytes == 4) ? 32'd0 : (32'd1 << (8 * nBytes));
      lane = (nBytes == 4) ? word : ((word >> (8 * off)) % laneRange);
      if (!v.write) begin
        if (nBytes != 4 && !v.uns && lane >= laneRange / 2) lane = lane - laneRange;
        v.expRdata = lane; v.expLat = 2; v.expRd = 1; v.expWr = 0;
        modelRdata = lane;
      end else begin
        if (nBytes == 4) begin
          newWord = v.wdata;
          v.expLat = 2; v.expRd = 0;
        end else begin
          newLane = v.wdata % laneRange;
          newWord = word - (lane << (8 * off)) + (newLane << (8 * off));
          v.expLat = 3; v.expRd = 1;
        end
        v.expWr = 1; v.expWrData = newWord; v.expRdata = '0;
        modelMem[wa] = newWord;
        modelRdata = '0;
      end
    end
  endtask

  task automatic driveReq(input vec_t v);
    req_write    = v.write;
    req_size     = v.size;
    req_unsigned = v.uns;
    req_addr     = v.addr;
    req_wdata    = v.wdata;
  endtask

  task automatic waitReady(input string tag);
    int n = 0;
    @(negedge clk);
    while (!req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) checkOutput({tag, ".readyTimeout"}, 32'(req_ready), 32'd1);
  endtask

  task automatic applyStimulus(input vec_t v, input string tag,
                               output logic [31:0] rdata, output logic err, output int lat,
                               output int nRd, output int nWr, output logic [7:0] wAddr,
                               output logic [31:0] wData, output logic pulseAfter);
    int r0, w0;
    waitReady(tag);
    r0 = rdCount;
    w0 = wrCount;
    driveReq(v);
    req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 1;
    while (!resp_valid && lat < 10) begin
      @(posedge clk); #1;
      lat++;
    end
    rdata = resp_rdata;
    err   = resp_err;
    nRd   = rdCount - r0;
    nWr   = wrCount - w0;
    wAddr = lastWrAddr;
    wData = lastWrData;
    @(posedge clk); #1;
    pulseAfter = resp_valid;
  endtask

  task automatic runVec(input vec_t v, input string tag);
    logic [31:0] rdata, wData;
    logic        err, pulseAfter;
    logic [7:0]  wAddr;
    int          lat, nRd, nWr;
    applyStimulus(v, tag, rdata, err, lat, nRd, nWr, wAddr, wData, pulseAfter);
    checkOutput({tag, ".rdata"}, rdata, v.expRdata);
    checkOutput({tag, ".err"}, 32'(err), 32'(v.expErr));
    checkOutput({tag, ".latency"}, lat, v.expLat);
    checkOutput({tag, ".reads"}, nRd, v.expRd);
    checkOutput({tag, ".writes"}, nWr, v.expWr);
    checkOutput({tag, ".pulse"}, 32'(pulseAfter), 32'd0);
    if (v.expWr == 1) begin
      checkOutput({tag, ".waddr"}, 32'(wAddr), 32'(v.addr >> 2));
      checkOutput({tag, ".wdata"}, wData, v.expWrData);
    end
  endtask

  // Three loads queued behind a permanently asserted req_valid.
  task automatic handshakeSeq();
    vec_t hv[3];
    int acc = 0, nResp = 0, cyc = 0, lowWhileValid = 0;
    int respCyc[3] = '{0, 0, 0};
    hv[0] = mkVec(1'b0, SIZE_W, 1'b0, 10'h010, 32'h0, '0, 1'b0, 0, 0, 0, '0);
    hv[1] = mkVec(1'b0, SIZE_H, 1'b0, 10'h012, 32'h0, '0, 1'b0, 0, 0, 0, '0);
    hv[2] = mkVec(1'b0, SIZE_B, 1'b1, 10'h014, 32'h0, '0, 1'b0, 0, 0, 0, '0);
    for (int i = 0; i < 3; i++) modelReq(hv[i]);
    waitReady("hs");
    driveReq(hv[0]);
    req_valid = 1'b1;
    while (nResp < 3 && cyc < 40) begin
      logic accNow;
      accNow = req_valid && req_ready;
      if (req_valid && !req_ready) lowWhileValid++;
      @(posedge clk); #1;
      cyc++;
      if (accNow) begin
        acc++;
        if (acc < 3) driveReq(hv[acc]);
        else req_valid = 1'b0;
      end
      if (resp_valid) begin
        checkOutput($sformatf("hs.rdata%0d", nResp), resp_rdata, hv[nResp].expRdata);
        respCyc[nResp] = cyc;
        nResp++;
      end
      @(negedge clk);
    end
    req_valid = 1'b0;
    checkOutput("hs.accepted", acc, 3);
    checkOutput("hs.responses", nResp, 3);
    checkOutput("hs.readyLowBusy", lowWhileValid, 4);
    checkOutput("hs.resp0Cycle", respCyc[0], 2);
    checkOutput("hs.resp1Cycle", respCyc[1], 5);
    checkOutput("hs.resp2Cycle", respCyc[2], 8);
  endtask

  task automatic resetInWriteSeq();
    vec_t v;
    int respSeen = 0;
    v = mkVec(1'b1, SIZE_W, 1'b0, 10'h320, 32'hA5A5_A5A5, '0, 1'b0, 0, 0, 0, '0);
    waitReady("rst");
    driveReq(v);
    req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    checkOutput("rst.inWrite", 32'(mem_write), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("rst.writeDrop", 32'(mem_write), 32'd0);
    checkOutput("rst.readyInReset", 32'(req_ready), 32'd1);
    repeat (2) begin
      @(posedge clk); #1;
      if (resp_valid) respSeen++;
    end
    @(negedge clk);
    rst_n = 1'b1;
    modelRdata = '0;
    repeat (4) begin
      @(posedge clk); #1;
      if (resp_valid) respSeen++;
    end
    checkOutput("rst.noResp", respSeen, 0);
    checkOutput("rst.readyAfter", 32'(req_ready), 32'd1);
    v = mkVec(1'b0, SIZE_W, 1'b0, 10'h010, 32'h0, '0, 1'b0, 0, 0, 0, '0);
    modelReq(v);
    runVec(v, "rst.next");
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got=timeout want=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vec_t vecs[$];
    vec_t v;
    rst_n = 1'b0;
    clearMem = 1'b1;
    req_valid = 1'b0; req_write = 1'b0; req_size = SIZE_B; req_unsigned = 1'b0;
    req_addr = '0; req_wdata = '0;
    modelRdata = '0;
    for (int i = 0; i < 256; i++) modelMem[i] = '0;
    #1;
    checkOutput("reset.req_ready", 32'(req_ready), 32'd1);
    checkOutput("reset.resp_valid", 32'(resp_valid), 32'd0);
    checkOutput("reset.resp_rdata", resp_rdata, 32'd0);
    checkOutput("reset.resp_err", 32'(resp_err), 32'd0);
    checkOutput("reset.mem_read", 32'(mem_read), 32'd0);
    checkOutput("reset.mem_write", 32'(mem_write), 32'd0);
    checkOutput("reset.mem_read_addr", 32'(mem_read_addr), 32'd0);
    checkOutput("reset.mem_write_addr", 32'(mem_write_addr), 32'd0);
    checkOutput("reset.mem_write_data", mem_write_data, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    clearMem = 1'b0;
    rst_n = 1'b1;

    //                 wr    size    uns   addr     wdata          rdata          err  lat rd wr wrdata
    vecs.push_back(mkVec(1'b1, SIZE_W, 1'b0, 10'h010, 32'hDEAD_BEEF, 32'h0000_0000, 1'b0, 2, 0, 1, 32'hDEAD_BEEF));
    vecs.push_back(mkVec(1'b0, SIZE_W, 1'b0, 10'h010, 32'h0,         32'hDEAD_BEEF, 1'b0, 2, 1, 0, 32'h0));
    vecs.push_back(mkVec(1'b1, SIZE_W, 1'b0, 10'h010, 32'h1122_3344, 32'h0000_0000, 1'b0, 2, 0, 1, 32'h1122_3344));
    vecs.push_back(mkVec(1'b1, SIZE_B, 1'b0, 10'h012, 32'h1234_56AA, 32'h0000_0000, 1'b0, 3, 1, 1, 32'h11AA_3344));
    vecs.push_back(mkVec(1'b1, SIZE_W, 1'b0, 10'h010, 32'h8000_FF7F, 32'h0000_0000, 1'b0, 2, 0, 1, 32'h8000_FF7F));
    vecs.push_back(mkVec(1'b0, SIZE_B, 1'b0, 10'h011, 32'h0,         32'hFFFF_FFFF, 1'b0, 2, 1, 0, 32'h0));
    vecs.push_back(mkVec(1'b0, SIZE_B, 1'b1, 10'h011, 32'h0,         32'h0000_00FF, 1'b0, 2, 1, 0, 32'h0));
    vecs.push_back(mkVec(1'b0, SIZE_H, 1'b0, 10'h012, 32'h0,         32'hFFFF_8000, 1'b0, 2, 1, 0, 32'h0));
    vecs.push_back(mkVec(1'b0, SIZE_H, 1'b1, 10'h010, 32'h0,         32'h0000_FF7F, 1'b0, 2, 1, 0, 32'h0));
    vecs.push_back(mkVec(1'b0, SIZE_H, 1'b0, 10'h013, 32'h0,         32'h0000_FF7F, 1'b1, 1, 0, 0, 32'h0));
    vecs.push_back(mkVec(1'b1, SIZE_W, 1'b0, 10'h016, 32'hFFFF_FFFF, 32'h0000_FF7F, 1'b1, 1, 0, 0, 32'h0));
    vecs.push_back(mkVec(1'b0, SIZE_W, 1'b0, 10'h010, 32'h0,         32'h8000_FF7F, 1'b0, 2, 1, 0, 32'h0));
    vecs.push_back(mkVec(1'b0, SIZE_W, 1'b0, 10'h014, 32'h0,         32'h0000_0000, 1'b0, 2, 1, 0, 32'h0));
    vecs.push_back(mkVec(1'b1, SIZE_H, 1'b0, 10'h012, 32'hCAFE_1234, 32'h0000_0000, 1'b0, 3, 1, 1, 32'h1234_FF7F));
    vecs.push_back(mkVec(1'b0, SIZE_B, 1'b0, 10'h013, 32'h0,         32'h0000_0012, 1'b0, 2, 1, 0, 32'h0));
    vecs.push_back(mkVec(1'b0, 2'b11,  1'b0, 10'h010, 32'h0,         32'h0000_0012, 1'b1, 1, 0, 0, 32'h0));
    vecs.push_back(mkVec(1'b0, SIZE_B, 1'b0, 10'h010, 32'h0,         32'h0000_007F, 1'b0, 2, 1, 0, 32'h0));
    vecs.push_back(mkVec(1'b0, SIZE_H, 1'b0, 10'h012, 32'h0,         32'h0000_1234, 1'b0, 2, 1, 0, 32'h0));

    for (int i = 0; i < vecs.size(); i++) begin
      v = vecs[i];
      modelReq(v);
      runVec(vecs[i], $sformatf("vec%0d", i));
    end

    handshakeSeq();

    for (int i = 0; i < 150; i++) begin
      v = mkVec(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                10'($urandom_range(0, 63)), $urandom, '0, 1'b0, 0, 0, 0, '0);
      modelReq(v);
      runVec(v, $sformatf("rand%0d", i));
    end

    resetInWriteSeq();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
